// File: rtl/raster_tracker_pkg.sv
// Shared screen geometry and tracker state encoding.
package raster_tracker_pkg;

    localparam int WIDTH  = 20;
    localparam int HEIGHT = 10;
    localparam int X_BITS = $clog2(WIDTH);
    localparam int Y_BITS = $clog2(HEIGHT);

    typedef enum logic {
        SYNC = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/raster_tracker_if.sv
// Pixel stream in, frame bounding box out.
import raster_tracker_pkg::*;

interface raster_tracker_if #(
    parameter int XB = X_BITS,
    parameter int YB = Y_BITS
);
    logic              signal;
    logic              move;
    logic signed [YB:0] top;
    logic signed [YB:0] bottom;
    logic signed [XB:0] left;
    logic signed [XB:0] right;
    logic              valid;
    logic              empty;
    logic              overrun;

    modport master (
        output signal, move,
        input  top, bottom, left, right, valid, empty, overrun
    );

    modport slave (
        input  signal, move,
        output top, bottom, left, right, valid, empty, overrun
    );
endinterface

// File: rtl/raster_tracker_counter.sv
// Column/row raster position counter with frame terminal-count flag.
import raster_tracker_pkg::*;

module raster_counter #(
    parameter int width  = WIDTH,
    parameter int height = HEIGHT,
    localparam int xBits = $clog2(width),
    localparam int yBits = $clog2(height)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clear,
    output logic [xBits-1:0] o_col,
    output logic [yBits-1:0] o_row,
    output logic             o_tc
);

    localparam logic [xBits-1:0] COL_LAST = xBits'(width - 1);
    localparam logic [yBits-1:0] ROW_LAST = yBits'(height - 1);

    logic [xBits-1:0] r_col;
    logic [yBits-1:0] r_row;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;
    assign o_tc  = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/raster_tracker.sv
// Tracks the bounding box of lit pixels per frame and publishes it on each
// end-of-frame strobe once the raster has been synchronised.
import raster_tracker_pkg::*;

module raster_tracker #(
    parameter int width  = WIDTH,
    parameter int height = HEIGHT
) (
    input logic             clock,
    input logic             reset,
    raster_tracker_if.slave bus
);

    localparam int xBits = $clog2(width);
    localparam int yBits = $clog2(height);

    localparam logic signed [yBits:0] ROW_SENT = (yBits+1)'(height);
    localparam logic signed [xBits:0] COL_SENT = (xBits+1)'(width);
    localparam logic signed [yBits:0] ROW_NONE = {(yBits+1){1'b1}};
    localparam logic signed [xBits:0] COL_NONE = {(xBits+1){1'b1}};

    state_t                  r_state;
    logic signed [yBits:0]   r_min_row, r_max_row;
    logic signed [xBits:0]   r_min_col, r_max_col;
    logic                    r_lit;
    logic signed [yBits:0]   r_top, r_bottom;
    logic signed [xBits:0]   r_left, r_right;
    logic                    r_valid, r_empty, r_overrun;

    logic [xBits-1:0]        w_col;
    logic [yBits-1:0]        w_row;
    logic                    w_tc;
    logic                    w_scan;
    logic signed [yBits:0]   w_row_s;
    logic signed [xBits:0]   w_col_s;
    logic signed [yBits:0]   w_min_row, w_max_row;
    logic signed [xBits:0]   w_min_col, w_max_col;
    logic                    w_lit;

    assign w_scan = (r_state == SCAN);

    raster_counter #(
        .width (width),
        .height(height)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .i_en   (w_scan),
        .i_clear(bus.move),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_tc   (w_tc)
    );

    assign w_row_s = $signed({1'b0, w_row});
    assign w_col_s = $signed({1'b0, w_col});

    // Accumulator values including the pixel on the current clock.
    always_comb begin
        w_min_row = r_min_row;
        w_max_row = r_max_row;
        w_min_col = r_min_col;
        w_max_col = r_max_col;
        w_lit     = r_lit;
        if (bus.signal) begin
            if (w_row_s < r_min_row) w_min_row = w_row_s;
            if (w_row_s > r_max_row) w_max_row = w_row_s;
            if (w_col_s < r_min_col) w_min_col = w_col_s;
            if (w_col_s > r_max_col) w_max_col = w_col_s;
            w_lit = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= SYNC;
            r_min_row <= ROW_SENT;
            r_max_row <= ROW_NONE;
            r_min_col <= COL_SENT;
            r_max_col <= COL_NONE;
            r_lit     <= 1'b0;
            r_top     <= '0;
            r_bottom  <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_empty   <= 1'b1;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            case (r_state)
                SYNC: begin
                    if (bus.move) r_state <= SCAN;
                end
                SCAN: begin
                    if (bus.move) begin
                        r_valid <= 1'b1;
                        r_empty <= ~w_lit;
                        // An empty frame keeps the previously published box.
                        if (w_lit) begin
                            r_top    <= w_min_row;
                            r_bottom <= w_max_row;
                            r_left   <= w_min_col;
                            r_right  <= w_max_col;
                        end
                        r_min_row <= ROW_SENT;
                        r_max_row <= ROW_NONE;
                        r_min_col <= COL_SENT;
                        r_max_col <= COL_NONE;
                        r_lit     <= 1'b0;
                    end else begin
                        r_min_row <= w_min_row;
                        r_max_row <= w_max_row;
                        r_min_col <= w_min_col;
                        r_max_col <= w_max_col;
                        r_lit     <= w_lit;
                        if (w_tc) r_overrun <= 1'b1;
                    end
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    assign bus.top     = r_top;
    assign bus.bottom  = r_bottom;
    assign bus.left    = r_left;
    assign bus.right   = r_right;
    assign bus.valid   = r_valid;
    assign bus.empty   = r_empty;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_raster_tracker.sv
// Directed bench for raster_tracker on a 20x10 screen.
module tb_raster_tracker;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   vcnt, ocnt;

    raster_tracker_if #(.XB(5), .YB(4)) rif ();

    raster_tracker #(.width(20), .height(10)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (rif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_box(input string tag, input int t, input int b, input int l, input int r);
        check({tag, "_top"},    int'(rif.top),    t);
        check({tag, "_bottom"}, int'(rif.bottom), b);
        check({tag, "_left"},   int'(rif.left),   l);
        check({tag, "_right"},  int'(rif.right),  r);
    endtask

    // Drives npix pixels from (0,0); a pixel is lit inside the rectangle
    // or, with corners set, at (0,0) and (9,19). Move rides the last pixel.
    task automatic frame(input int r0, input int r1, input int c0, input int c1,
                         input bit corners, input int npix, input bit do_move,
                         output int vc, output int oc);
        int r, c;
        bit mv;
        vc = 0;
        oc = 0;
        for (int p = 0; p < npix; p++) begin
            r  = p / 20;
            c  = p % 20;
            mv = do_move && (p == npix - 1);
            rif.signal = ((r >= r0) && (r <= r1) && (c >= c0) && (c <= c1)) ||
                         (corners && (((r == 0) && (c == 0)) || ((r == 9) && (c == 19))));
            rif.move   = mv;
            @(posedge clock);
            #1;
            if (!mv) begin
                vc += int'(rif.valid);
                oc += int'(rif.overrun);
            end
        end
        rif.move = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_box(tag, 0, 0, 0, 0);
        check({tag, "_empty"},   int'(rif.empty),   1);
        check({tag, "_valid"},   int'(rif.valid),   0);
        check({tag, "_overrun"}, int'(rif.overrun), 0);
    endtask

    initial begin
        rif.signal = 1'b0;
        rif.move   = 1'b0;
        #12;
        check_reset_state("rst");
        @(posedge clock);
        #1 reset = 1'b0;

        // Move during SYNC with lit pixels: nothing is published.
        frame(0, 9, 0, 19, 1'b0, 6, 1'b1, vcnt, ocnt);
        check("sync_valid", int'(rif.valid), 0);
        check("sync_vcnt", vcnt, 0);

        frame(3, 5, 7, 10, 1'b0, 200, 1'b1, vcnt, ocnt);
        check("f1_valid", int'(rif.valid), 1);
        check_box("f1", 3, 5, 7, 10);
        check("f1_empty", int'(rif.empty), 0);
        check("f1_vcnt", vcnt, 0);
        check("f1_ocnt", ocnt, 0);

        frame(1, 0, 0, 0, 1'b0, 200, 1'b1, vcnt, ocnt);
        check("f2_valid", int'(rif.valid), 1);
        check("f2_empty", int'(rif.empty), 1);
        check_box("f2", 3, 5, 7, 10);
        check("f2_vcnt", vcnt, 0);

        frame(1, 0, 0, 0, 1'b1, 200, 1'b1, vcnt, ocnt);
        check("f3_valid", int'(rif.valid), 1);
        check_box("f3", 0, 9, 0, 19);
        check("f3_empty", int'(rif.empty), 0);

        // 200 pixels with no move; pixel (2,2) lit and kept past the wrap.
        frame(2, 2, 2, 2, 1'b0, 200, 1'b0, vcnt, ocnt);
        check("ovr_pulse", int'(rif.overrun), 1);
        check("ovr_ocnt", ocnt, 1);
        check("ovr_vcnt", vcnt, 0);

        frame(3, 5, 7, 10, 1'b0, 200, 1'b1, vcnt, ocnt);
        check("f4_valid", int'(rif.valid), 1);
        check_box("f4", 2, 5, 2, 10);
        check("f4_ocnt", ocnt, 0);
        check("f4_vcnt", vcnt, 0);

        // Reset mid-frame at pixel 50.
        frame(1, 8, 0, 19, 1'b0, 50, 1'b0, vcnt, ocnt);
        #2 reset = 1'b1;
        #2 check_reset_state("midrst");
        @(posedge clock);
        #1 reset = 1'b0;

        frame(0, 9, 0, 19, 1'b0, 40, 1'b1, vcnt, ocnt);
        check("resync_valid", int'(rif.valid), 0);
        check("resync_vcnt", vcnt, 0);
        check("resync_empty", int'(rif.empty), 1);
        check("resync_top", int'(rif.top), 0);

        frame(6, 7, 1, 2, 1'b0, 200, 1'b1, vcnt, ocnt);
        check("f5_valid", int'(rif.valid), 1);
        check_box("f5", 6, 7, 1, 2);
        check("f5_empty", int'(rif.empty), 0);
        check("f5_vcnt", vcnt, 0);

        rif.signal = 1'b0;
        @(posedge clock);
        #1;
        check("f5_valid_fall", int'(rif.valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raster_tracker.md
RASTER_TRACKER -- requirements
Module: raster_tracker

Interface
REQ-001 Parameter: width, default 20, screen width in pixels.
REQ-002 Parameter: height, default 10, screen height in pixels.
REQ-003 Derived constants: xBits = $clog2(width); yBits = $clog2(height).
REQ-004 Port: clock  input  1  single clock for the whole block.
REQ-005 Port: reset  input  1  asynchronous, active-high.
REQ-006 Port: signal  input  1  raster pixel stream, one pixel per clock, 1 = pixel lit.
REQ-007 Port: move  input  1  end-of-frame strobe, high for one clock on the last pixel of a frame.
REQ-008 Port: top  output  signed [yBits:0]  first lit row of the last reported frame.
REQ-009 Port: bottom  output  signed [yBits:0]  last lit row, inclusive.
REQ-010 Port: left  output  signed [xBits:0]  first lit column.
REQ-011 Port: right  output  signed [xBits:0]  last lit column, inclusive.
REQ-012 Port: valid  output  1  one-clock pulse when new bounds are published.
REQ-013 Port: empty  output  1  last reported frame had no lit pixel.
REQ-014 Port: overrun  output  1  one-clock pulse when a frame exceeds width*height pixels.

Function
REQ-015 The block SHALL keep column and row counters: column 0..width-1 increments every clock in SCAN; on column width-1, column wraps to 0 and row increments.
REQ-016 States SHALL be SYNC and SCAN; SYNC -> SCAN on move; SCAN remains SCAN.
REQ-017 In SYNC, signal SHALL be ignored and no valid pulse SHALL be produced, including on the move that ends SYNC.
REQ-018 On the clock after any move, counters SHALL be at (row 0, column 0).
REQ-019 In SCAN, when signal=1 the frame accumulators SHALL update: min/max row, min/max column, and lit flag.
REQ-020 The pixel sampled on the move cycle SHALL be included in that frame.
REQ-021 On the move cycle in SCAN, top/bottom/left/right/empty SHALL be loaded from the accumulators (including that cycle's pixel), with valid=1 on the following clock only (latency 1).
REQ-022 If no pixel was lit, empty SHALL be 1 and top/bottom/left/right SHALL hold their previous values; valid still pulses.
REQ-023 Accumulators SHALL reinitialise on the move cycle: min to sentinel (height or width), max to -1, lit flag to 0.
REQ-024 Coordinates SHALL be zero-extended into the signed output widths; they are always non-negative.
REQ-025 If counters are at (height-1, width-1) in SCAN and move=0, overrun SHALL pulse for one clock on the next clock, counters wrap to (0,0), accumulators are kept, and no valid is produced.
REQ-026 Simultaneous move and overrun condition: move SHALL take precedence; no overrun pulse.

Reset
REQ-027 Reset SHALL force state SYNC, counters 0, accumulators to initial values, top/bottom/left/right 0, empty 1, valid 0, overrun 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first valid after reset follows the second move.

Structure
REQ-029 width, height, xBits, and yBits SHALL live in the shared pong parameters package/header used by bouncing and screen.
REQ-030 Column/row counting SHALL be a sub-module raster_counter (wrap, terminal-count output); min/max tracking and the FSM stay in raster_tracker.

Verification (width=20, height=10)
REQ-031 Reset, move, then a frame with lit rows 3-5 and columns 7-10 -> valid one clock after move; top=3, bottom=5, left=7, right=10, empty=0.
REQ-032 Frame with no lit pixels after REQ-031 -> valid pulse; empty=1; bounds stay 3/5/7/10.
REQ-033 Single lit pixels at (0,0) and (9,19), with the last pixel lit on the move cycle -> top=0, left=0, bottom=9, right=19.
REQ-034 In SCAN, 200 clocks without move -> overrun pulse once on clock 201; counters at (0,0); no valid.
REQ-035 Reset asserted at pixel 50 of a lit frame -> outputs return to reset values; signal ignored until move; no valid at the first move; correct bounds at the second move.
REQ-036 Move during SYNC with signal=1 -> no valid; next frame reports normally.
